hdlc_tx_serializer: RTL and testbench

Serial transmit stage of the HDLC controller. It pulls bytes from the Tx buffer and drives the `Tx` line one bit per clock. It generates the opening and closing flags, inserts a zero after every five consecutive ones, optionally appends a CRC-16 FCS, and emits the abort and idle patterns. It sits directly downstream of the Tx buffer and drives the serial output that the Rx channel consumes in loopback.

---
 rtl/hdlc_pkg.sv | 29 ++
 rtl/hdlc_tx_serializer_if.sv | 26 ++
 rtl/hdlc_crc16.sv | 36 +++
 rtl/hdlc_tx_serializer.sv | 211 +++++++++++++++++++++
 tb/tb_hdlc_tx_serializer.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hdlc_pkg.sv
// Shared HDLC transmit constants and state type.
// StFcs exists only when HDLC_TX_FCS_EN is defined.
package hdlc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStartFlag,
        StData,
`ifdef HDLC_TX_FCS_EN
        StFcs,
`endif
        StEndFlag,
        StAbort
    } tx_state_t;

    localparam logic [7:0]  HDLC_FLAG        = 8'h7E;
    localparam logic [7:0]  HDLC_ABORT       = 8'h7F;
    localparam logic [15:0] HDLC_CRC16_POLY  = 16'h8005;
    localparam int unsigned HDLC_STUFF_LIMIT = 5;

    function automatic logic [7:0] reverse8(input logic [7:0] value);
        logic [7:0] result;
        for (int i = 0; i < 8; i++) begin
            result[i] = value[7-i];
        end
        return result;
    endfunction

endpackage

// File: rtl/hdlc_tx_serializer_if.sv
// Tx buffer / serializer handshake bundle.
// master = buffer/controller side, slave = serializer side.
interface hdlc_tx_serializer_if;

    logic       Tx_Enable;
    logic       Tx_DataAvail;
    logic [7:0] Tx_Data;
    logic       Tx_AbortFrame;
    logic       Tx_RdBuff;
    logic       Tx_NewByte;
    logic       Tx_ValidFrame;
    logic       Tx_Done;
    logic       Tx_AbortedTrans;
    logic       Tx;

    modport master (
        output Tx_Enable, Tx_DataAvail, Tx_Data, Tx_AbortFrame,
        input  Tx_RdBuff, Tx_NewByte, Tx_ValidFrame, Tx_Done, Tx_AbortedTrans, Tx
    );

    modport slave (
        input  Tx_Enable, Tx_DataAvail, Tx_Data, Tx_AbortFrame,
        output Tx_RdBuff, Tx_NewByte, Tx_ValidFrame, Tx_Done, Tx_AbortedTrans, Tx
    );

endinterface

// File: rtl/hdlc_crc16.sv
// Bit-serial CRC-16 (G = x^16 + x^15 + x^2 + 1), MSB-first, no final complement.
module hdlc_crc16
    import hdlc_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Init,
    input  logic        Shift,
    input  logic        DataBit,
    output logic [15:0] Crc
);

    logic [15:0] crcQ, crcD;
    logic        feedback;

    always_comb begin
        crcD     = crcQ;
        feedback = DataBit ^ crcQ[15];
        if (Init) begin
            crcD = '0;
        end else if (Shift) begin
            crcD = {crcQ[14:0], 1'b0} ^ (feedback ? HDLC_CRC16_POLY : 16'h0000);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            crcQ <= '0;
        end else begin
            crcQ <= crcD;
        end
    end

    assign Crc = crcQ;

endmodule

// File: rtl/hdlc_tx_serializer.sv
// HDLC serial transmitter: flags, zero insertion, abort, optional CRC-16 FCS.
// Optional FCS is compiled in with HDLC_TX_FCS_EN.
module hdlc_tx_serializer
    import hdlc_pkg::*;
(
    input logic                 Clk,
    input logic                 Rst,
    hdlc_tx_serializer_if.slave txIf
);

    // Abort pattern goes on the line as 0 followed by seven 1s.
    localparam logic [7:0] AbortLine  = reverse8(HDLC_ABORT);
    localparam logic [2:0] StuffLimit = 3'(HDLC_STUFF_LIMIT);

    tx_state_t  stateQ, stateD;
    logic [2:0] bitCntQ, bitCntD;
    logic [7:0] shiftQ, shiftD;
    logic [2:0] onesQ, onesD;
    logic       txQ, txD;
    logic       newByteQ, newByteD;
    logic       validQ, validD;
    logic       doneQ, doneD;
    logic       abortedQ, abortedD;
    logic       rdBuff;
    logic       payload;
    logic       lastBit;
    logic       inFrame;

`ifdef HDLC_TX_FCS_EN
    logic [15:0] fcsQ, fcsD;
    logic        fcsSecondQ, fcsSecondD;
    logic [15:0] crc;
    logic        crcInit;
    logic        dataBit;

    hdlc_crc16 u_crc (
        .Clk     (Clk),
        .Rst     (Rst),
        .Init    (crcInit),
        .Shift   (dataBit),
        .DataBit (txD),
        .Crc     (crc)
    );
`endif

    assign lastBit = (bitCntQ == 3'd7);
    assign inFrame = (stateQ != StIdle) && (stateQ != StAbort);

    always_comb begin
        stateD   = stateQ;
        bitCntD  = bitCntQ;
        shiftD   = shiftQ;
        onesD    = '0;
        txD      = 1'b1;
        newByteD = 1'b0;
        validD   = validQ;
        doneD    = 1'b0;
        abortedD = 1'b0;
        rdBuff   = 1'b0;
        payload  = 1'b0;
`ifdef HDLC_TX_FCS_EN
        fcsD       = fcsQ;
        fcsSecondD = fcsSecondQ;
        crcInit    = 1'b0;
        dataBit    = 1'b0;
`endif
        if (inFrame && txIf.Tx_AbortFrame) begin
            stateD   = StAbort;
            bitCntD  = '0;
            txD      = AbortLine[0];
            shiftD   = AbortLine >> 1;
            validD   = 1'b0;
            abortedD = 1'b1;
        end else if (onesQ == StuffLimit) begin
            // Stuffed zero: bit position and shift register hold this cycle.
            txD = 1'b0;
        end else begin
            unique case (stateQ)
                StIdle: begin
                    if (txIf.Tx_Enable && txIf.Tx_DataAvail) begin
                        stateD  = StStartFlag;
                        bitCntD = '0;
                        txD     = HDLC_FLAG[0];
                        shiftD  = HDLC_FLAG >> 1;
                        validD  = 1'b1;
`ifdef HDLC_TX_FCS_EN
                        crcInit = 1'b1;
`endif
                    end
                end
                StStartFlag, StData: begin
                    if (!lastBit) begin
                        bitCntD = bitCntQ + 3'd1;
                        txD     = shiftQ[0];
                        shiftD  = shiftQ >> 1;
                        payload = (stateQ == StData);
`ifdef HDLC_TX_FCS_EN
                        dataBit = (stateQ == StData);
`endif
                    end else if (txIf.Tx_DataAvail) begin
                        rdBuff   = 1'b1;
                        stateD   = StData;
                        bitCntD  = '0;
                        txD      = txIf.Tx_Data[0];
                        shiftD   = {1'b0, txIf.Tx_Data[7:1]};
                        newByteD = 1'b1;
                        payload  = 1'b1;
`ifdef HDLC_TX_FCS_EN
                        dataBit  = 1'b1;
`endif
                    end else begin
`ifdef HDLC_TX_FCS_EN
                        stateD     = StFcs;
                        bitCntD    = '0;
                        fcsSecondD = 1'b0;
                        txD        = crc[15];
                        fcsD       = {crc[14:0], 1'b0};
                        payload    = 1'b1;
`else
                        stateD  = StEndFlag;
                        bitCntD = '0;
                        txD     = HDLC_FLAG[0];
                        shiftD  = HDLC_FLAG >> 1;
`endif
                    end
                end
`ifdef HDLC_TX_FCS_EN
                StFcs: begin
                    if (!lastBit || !fcsSecondQ) begin
                        bitCntD = bitCntQ + 3'd1;
                        txD     = fcsQ[15];
                        fcsD    = {fcsQ[14:0], 1'b0};
                        payload = 1'b1;
                        if (lastBit) begin
                            fcsSecondD = 1'b1;
                        end
                    end else begin
                        stateD  = StEndFlag;
                        bitCntD = '0;
                        txD     = HDLC_FLAG[0];
                        shiftD  = HDLC_FLAG >> 1;
                    end
                end
`endif
                StEndFlag, StAbort: begin
                    if (!lastBit) begin
                        bitCntD = bitCntQ + 3'd1;
                        txD     = shiftQ[0];
                        shiftD  = shiftQ >> 1;
                        doneD   = (stateQ == StEndFlag) && (bitCntQ == 3'd6);
                    end else begin
                        stateD  = StIdle;
                        bitCntD = '0;
                        validD  = 1'b0;
                    end
                end
                default: begin
                    stateD = StIdle;
                end
            endcase
            if (payload) begin
                onesD = txD ? onesQ + 3'd1 : 3'd0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            stateQ   <= StIdle;
            bitCntQ  <= '0;
            shiftQ   <= '0;
            onesQ    <= '0;
            txQ      <= 1'b1;
            newByteQ <= 1'b0;
            validQ   <= 1'b0;
            doneQ    <= 1'b0;
            abortedQ <= 1'b0;
        end else begin
            stateQ   <= stateD;
            bitCntQ  <= bitCntD;
            shiftQ   <= shiftD;
            onesQ    <= onesD;
            txQ      <= txD;
            newByteQ <= newByteD;
            validQ   <= validD;
            doneQ    <= doneD;
            abortedQ <= abortedD;
        end
    end

`ifdef HDLC_TX_FCS_EN
    always_ff @(posedge Clk) begin
        if (Rst) begin
            fcsQ       <= '0;
            fcsSecondQ <= 1'b0;
        end else begin
            fcsQ       <= fcsD;
            fcsSecondQ <= fcsSecondD;
        end
    end
`endif

    // Never pop the buffer while the frame is being dropped by reset.
    assign txIf.Tx_RdBuff       = rdBuff & ~Rst;
    assign txIf.Tx_NewByte      = newByteQ;
    assign txIf.Tx_ValidFrame   = validQ;
    assign txIf.Tx_Done         = doneQ;
    assign txIf.Tx_AbortedTrans = abortedQ;
    assign txIf.Tx              = txQ;

endmodule

// File: tb/tb_hdlc_tx_serializer.sv
// Self-checking bench for hdlc_tx_serializer: randomized frames vs. a bit-stream model.
// Define HDLC_TX_FCS_EN for both RTL and bench to exercise the FCS build.
module tb_hdlc_tx_serializer;

    typedef logic [7:0] byte_q_t[$];

    logic    Clk = 1'b0;
    logic    Rst;
    int      checks = 0;
    int      passes = 0;
    byte_q_t buffer;
    bit      lastLine[$];

    hdlc_tx_serializer_if txIf ();

    hdlc_tx_serializer dut (
        .Clk  (Clk),
        .Rst  (Rst),
        .txIf (txIf)
    );

    always #5 Clk = ~Clk;

    function automatic void refresh_buffer();
        txIf.Tx_DataAvail = (buffer.size() > 0);
        txIf.Tx_Data      = (buffer.size() > 0) ? buffer[0] : 8'h00;
    endfunction

    // {Tx, RdBuff, NewByte, ValidFrame, Done, AbortedTrans}
    function automatic logic [5:0] observe();
        return {txIf.Tx, txIf.Tx_RdBuff, txIf.Tx_NewByte, txIf.Tx_ValidFrame,
                txIf.Tx_Done, txIf.Tx_AbortedTrans};
    endfunction

    // Polynomial division by x^16+x^15+x^2+1, message bits in order, zero seed.
    function automatic logic [15:0] crc16(input bit msg[$]);
        logic [15:0] r = '0;
        foreach (msg[k]) begin
            logic top = r[15] ^ msg[k];
            r = {r[14:0], 1'b0};
            if (top) r = r ^ 16'h8005;
        end
        return r;
    endfunction

    task automatic check_idle(input string name, input int n);
        logic [5:0] got;
        for (int c = 0; c < n; c++) begin
            @(negedge Clk);
            got = observe();
            checks++;
            if (got !== 6'b100000)
                $display("FAIL %s cycle %0d: got {Tx,Rd,New,Valid,Done,Abt}=%b want %b",
                         name, c, got, 6'b100000);
            else passes++;
            @(posedge Clk);
            #1;
        end
    endtask

    // Starts a frame now (caller sits 1 time unit after a rising edge) and checks every cycle.
    task automatic run_frame(input string name, input byte_q_t data, input int abortByte,
                             input int abortBit, input bit abortAtStart, input int idleAfter);
        logic [7:0] flag = 8'h7E;
        bit         stream[$];
        bit         first[$];
        bit         expTx[$];
        bit         expNew[$];
        int         posOf[$];
        int         ones = 0;
        int         cut = -1;
        int         len;
        int         pops = 0;
        bit         rd;
        logic [5:0] want, got;

        foreach (data[j]) begin
            for (int i = 0; i < 8; i++) begin
                stream.push_back(data[j][i]);
                first.push_back(i == 0);
            end
        end
`ifdef HDLC_TX_FCS_EN
        begin
            logic [15:0] fcs = crc16(stream);
            for (int i = 15; i >= 0; i--) begin
                stream.push_back(fcs[i]);
                first.push_back(1'b0);
            end
        end
`endif
        for (int i = 0; i < 8; i++) begin
            expTx.push_back(flag[i]);
            expNew.push_back(1'b0);
        end
        foreach (stream[k]) begin
            if (k < data.size() * 8) posOf.push_back(expTx.size());
            expTx.push_back(stream[k]);
            expNew.push_back(first[k]);
            ones = stream[k] ? ones + 1 : 0;
            if (ones == 5) begin
                expTx.push_back(1'b0);
                expNew.push_back(1'b0);
                ones = 0;
            end
        end
        for (int i = 0; i < 8; i++) begin
            expTx.push_back(flag[i]);
            expNew.push_back(1'b0);
        end
        len = expTx.size();
        if (abortByte >= 0) begin
            cut = posOf[abortByte * 8 + abortBit];
            len = cut + 9;
            for (int c = cut + 1; c < len; c++) begin
                expTx[c]  = (c != cut + 1);
                expNew[c] = 1'b0;
            end
        end

        lastLine.delete();
        buffer = data;
        refresh_buffer();
        txIf.Tx_Enable     = 1'b1;
        txIf.Tx_AbortFrame = abortAtStart;
        @(posedge Clk);
        #1;
        txIf.Tx_Enable     = 1'b0;
        txIf.Tx_AbortFrame = 1'b0;

        for (int c = 0; c < len; c++) begin
            if (c == cut) txIf.Tx_AbortFrame = 1'b1;
            @(negedge Clk);
            want = {expTx[c], (c + 1 < len) && expNew[c + 1], expNew[c],
                    (cut < 0) || (c <= cut), (cut < 0) && (c == len - 1),
                    (cut >= 0) && (c == cut + 1)};
            got = observe();
            lastLine.push_back(txIf.Tx);
            checks++;
            if (got !== want)
                $display("FAIL %s cycle %0d: got {Tx,Rd,New,Valid,Done,Abt}=%b want %b",
                         name, c, got, want);
            else passes++;
            rd = txIf.Tx_RdBuff;
            @(posedge Clk);
            #1;
            txIf.Tx_AbortFrame = 1'b0;
            if (rd && buffer.size() > 0) begin
                void'(buffer.pop_front());
                pops++;
            end
            refresh_buffer();
        end

        if (cut < 0) begin
            checks++;
            if (pops !== data.size())
                $display("FAIL %s pops: got %0d want %0d", name, pops, data.size());
            else passes++;
        end
        buffer.delete();
        refresh_buffer();
        check_idle({name, "_idle"}, idleAfter);
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        check_idle("reset_idle", 20);
    endtask

    task automatic test_ignored_requests();
        txIf.Tx_Enable = 1'b1;
        check_idle("enable_no_data", 3);
        txIf.Tx_Enable     = 1'b0;
        txIf.Tx_AbortFrame = 1'b1;
        check_idle("abort_in_idle", 2);
        txIf.Tx_AbortFrame = 1'b0;
    endtask

    task automatic test_single_ff();
        byte_q_t d;
        d.push_back(8'hFF);
        run_frame("single_ff", d, -1, 0, 1'b0, 2);
    endtask

    task automatic test_stuff_carry();
        byte_q_t d;
        d.push_back(8'hF0);
        d.push_back(8'h01);
        run_frame("carry_f0_01", d, -1, 0, 1'b0, 2);
        d.delete();
        d.push_back(8'h1F);
        d.push_back(8'h01);
        run_frame("carry_1f_01", d, -1, 0, 1'b0, 2);
    endtask

    task automatic test_abort();
        byte_q_t d;
        d.push_back(8'h12);
        d.push_back(8'hFF);
        d.push_back(8'h56);
        run_frame("abort_mid", d, 1, 3, 1'b0, 3);
    endtask

    task automatic test_enable_beats_abort();
        byte_q_t d;
        d.push_back(8'hA5);
        run_frame("enable_wins", d, -1, 0, 1'b1, 2);
    endtask

    task automatic test_back_to_back();
        byte_q_t a, b;
        a.push_back(8'h7E);
        b.push_back(8'h3C);
        b.push_back(8'hFF);
        run_frame("b2b_first", a, -1, 0, 1'b0, 0);
        run_frame("b2b_second", b, -1, 0, 1'b0, 2);
    endtask

    task automatic test_reset_mid_frame();
        byte_q_t d;
        bit      rd;
        buffer.push_back(8'hA5);
        buffer.push_back(8'h3C);
        buffer.push_back(8'hFF);
        refresh_buffer();
        txIf.Tx_Enable = 1'b1;
        @(posedge Clk);
        #1;
        txIf.Tx_Enable = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge Clk);
            rd = txIf.Tx_RdBuff;
            @(posedge Clk);
            #1;
            if (rd && buffer.size() > 0) void'(buffer.pop_front());
            refresh_buffer();
        end
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        buffer.delete();
        refresh_buffer();
        check_idle("reset_mid_idle", 3);
        d.push_back(8'h81);
        d.push_back(8'hFF);
        run_frame("after_reset", d, -1, 0, 1'b0, 2);
    endtask

    task automatic test_random();
        for (int f = 0; f < 8; f++) begin
            byte_q_t d;
            int      n = $urandom_range(1, 6);
            for (int j = 0; j < n; j++) begin
                d.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
            end
            if (f == 5 && n >= 2)
                run_frame("random_abort", d, $urandom_range(1, n - 1), $urandom_range(0, 7),
                          1'b0, 1);
            else
                run_frame("random", d, -1, 0, 1'b0, $urandom_range(0, 2));
        end
    endtask

`ifdef HDLC_TX_FCS_EN
    task automatic test_fcs();
        byte_q_t d;
        bit      body[$];
        int      ones = 0;
        d.push_back(8'h01);
        run_frame("fcs_01", d, -1, 0, 1'b0, 2);
        for (int k = 8; k < lastLine.size() - 8; k++) begin
            if (ones == 5) begin
                ones = 0;
                continue;
            end
            body.push_back(lastLine[k]);
            ones = lastLine[k] ? ones + 1 : 0;
        end
        checks++;
        if (body.size() != 24 || crc16(body) !== 16'h0000)
            $display("FAIL fcs_remainder: got bits=%0d rem=%h want bits=24 rem=0000",
                     body.size(), crc16(body));
        else passes++;
    endtask
`endif

    initial begin
        Rst                = 1'b1;
        txIf.Tx_Enable     = 1'b0;
        txIf.Tx_AbortFrame = 1'b0;
        refresh_buffer();
        test_reset();
        test_ignored_requests();
        test_single_ff();
        test_stuff_carry();
        test_abort();
        test_enable_beats_abort();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef HDLC_TX_FCS_EN
        test_fcs();
`endif
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
